// File: rtl/counter_scheduler.sv
// counter_scheduler: round-robin sharing of one W-bit up-counter among N_REQ requesters.
// Optional COUNTER_SCHED_STATS_EN adds run_cnt, the number of completed runs.
module counter_scheduler #(
    parameter int N_REQ = 4,
    parameter int W     = 4
) (
    input  logic               clock,
    input  logic               clear,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] len,
    output logic [N_REQ-1:0]   grant,
    output logic [N_REQ-1:0]   done,
    output logic [W-1:0]       q,
    output logic               busy
`ifdef COUNTER_SCHED_STATS_EN
    ,
    output logic [7:0]         run_cnt
`endif
);
    localparam int PW = $clog2(N_REQ);
    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;
    state_t           r_state, w_state;
    logic [N_REQ-1:0] r_grant, w_grant, r_done, w_done;
    logic [W-1:0]     r_q, w_q, r_tgt, w_tgt;
    logic [PW-1:0]    r_ptr, w_ptr, w_sel, w_idx;
    logic             w_any, w_own;
    // Scan downward so the lowest offset from the pointer wins.
    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        w_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_idx = PW'((int'(r_ptr) + k) % N_REQ);
            if (req[w_idx]) begin
                w_any = 1'b1;
                w_sel = w_idx;
            end
        end
    end
    assign w_own = |(req & r_grant);
    always_comb begin
        w_state = r_state;
        w_grant = r_grant;
        w_done  = '0;
        w_q     = r_q;
        w_tgt   = r_tgt;
        w_ptr   = r_ptr;
        case (r_state)
            IDLE: begin
                w_grant = '0;
                w_q     = '0;
                if (w_any) begin
                    w_grant = N_REQ'(1) << w_sel;
                    w_tgt   = len[int'(w_sel)*W +: W];
                    w_ptr   = (w_sel == PW'(N_REQ - 1)) ? '0 : w_sel + 1'b1;
                    w_state = COUNT;
                end
            end
            COUNT: begin
                if (!w_own) begin
                    w_state = IDLE;
                    w_grant = '0;
                    w_q     = '0;
                end else if (r_q == r_tgt) begin
                    w_state = DONE;
                    w_done  = r_grant;
                end else begin
                    w_q = r_q + 1'b1;
                end
            end
            default: begin
                w_state = IDLE;
                w_grant = '0;
                w_q     = '0;
            end
        endcase
    end
    always_ff @(posedge clock) begin
        if (clear) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_done  <= '0;
            r_q     <= '0;
            r_tgt   <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state;
            r_grant <= w_grant;
            r_done  <= w_done;
            r_q     <= w_q;
            r_tgt   <= w_tgt;
            r_ptr   <= w_ptr;
        end
    end
    assign grant = r_grant;
    assign done  = r_done;
    assign q     = r_q;
    assign busy  = (r_state != IDLE);
`ifdef COUNTER_SCHED_STATS_EN
    logic [7:0] r_run_cnt;
    always_ff @(posedge clock) begin
        if (clear)
            r_run_cnt <= '0;
        else if (r_state == COUNT && w_state == DONE)
            r_run_cnt <= r_run_cnt + 8'd1;
    end
    assign run_cnt = r_run_cnt;
`endif
endmodule
